updown_counter_bcd: RTL and testbench

//  Parametrised up/down counter core with selectable binary or packed-BCD counting.

---
 rtl/counter_pkg.sv | 88 ++++++++
 rtl/counter_digit_scan.sv | 46 ++++
 rtl/updown_counter_bcd.sv | 144 ++++++++++++++
 tb/tb_updown_counter_bcd.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and BCD digit-ripple helpers for the up/down counter core.
// Helpers work on a fixed-size vector; callers pass the live digit count.
package counter_pkg;

    localparam logic MODE_BIN = 1'b0;
    localparam logic MODE_BCD = 1'b1;

    localparam int unsigned BCD_MAX_DIGITS = 16;
    localparam int unsigned BCD_BITS       = 4 * BCD_MAX_DIGITS;

    typedef logic [BCD_BITS-1:0] bcd_vec_t;

    typedef struct packed {
        logic     carry;
        bcd_vec_t value;
    } bcd_res_t;

    typedef enum logic [2:0] {
        ACT_IDLE,
        ACT_LOAD,
        ACT_MODE_CHG,
        ACT_HOLD,
        ACT_STEP
    } action_t;

    // carry is set only when every live digit was 9, i.e. the count wrapped to 0
    function automatic bcd_res_t bcd_inc(input bcd_vec_t v, input int unsigned digits);
        bcd_res_t   r;
        logic       c;
        logic [3:0] nib;
        r = '0;
        c = 1'b1;
        for (int unsigned i = 0; i < BCD_MAX_DIGITS; i++) begin
            if (i < digits) begin
                nib = v[4*i +: 4];
                if (c) begin
                    if (nib >= 4'd9) begin
                        nib = 4'd0;
                    end else begin
                        nib = nib + 4'd1;
                        c   = 1'b0;
                    end
                end
                r.value[4*i +: 4] = nib;
            end
        end
        r.carry = c;
        return r;
    endfunction

    function automatic bcd_res_t bcd_dec(input bcd_vec_t v, input int unsigned digits);
        bcd_res_t   r;
        logic       b;
        logic [3:0] nib;
        r = '0;
        b = 1'b1;
        for (int unsigned i = 0; i < BCD_MAX_DIGITS; i++) begin
            if (i < digits) begin
                nib = v[4*i +: 4];
                if (b) begin
                    if (nib == 4'd0) begin
                        nib = 4'd9;
                    end else begin
                        nib = nib - 4'd1;
                        b   = 1'b0;
                    end
                end
                r.value[4*i +: 4] = nib;
            end
        end
        r.carry = b;
        return r;
    endfunction

    function automatic bcd_vec_t bcd_clamp(input bcd_vec_t v, input int unsigned digits);
        bcd_vec_t   r;
        logic [3:0] nib;
        r = '0;
        for (int unsigned i = 0; i < BCD_MAX_DIGITS; i++) begin
            if (i < digits) begin
                nib = v[4*i +: 4];
                r[4*i +: 4] = (nib > 4'd9) ? 4'd9 : nib;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_digit_scan.sv
// Free-running multiplexed-display scanner: prescaler, one-hot digit rotate
// and the nibble mux that follows the active digit.
module counter_digit_scan import counter_pkg::*; #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   nibbles,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [3:0]            digit_val
);

    logic [SCAN_DIV-1:0] prescaler;
    logic [DIGITS-1:0]   sel_rot;

    // rotate left: bit i takes bit i-1, MSB wraps to LSB
    always_comb begin
        sel_rot = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            sel_rot[i] = digit_sel[(i + DIGITS - 1) % DIGITS];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            digit_sel <= DIGITS'(1);
        end else begin
            prescaler <= prescaler + SCAN_DIV'(1);
            if (&prescaler) begin
                digit_sel <= sel_rot;
            end
        end
    end

    always_comb begin
        digit_val = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (digit_sel[i]) begin
                digit_val = digit_val | nibbles[4*i +: 4];
            end
        end
    end

endmodule

// File: rtl/updown_counter_bcd.sv
// Up/down counter core with binary or packed-BCD counting, load, wrap/saturate,
// terminal-count pulse, sticky overflow and a display digit scanner.
module updown_counter_bcd import counter_pkg::*; #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              up_down,
    input  logic              hold,
    input  logic              mode,
    input  logic              sat,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              clr_ovf,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              ovf,
    output logic [DIGITS-1:0] digit_sel,
    output logic [3:0]        digit_val
);

    localparam int unsigned BCD_W = 4 * DIGITS;

    if (DIGITS < 1 || DIGITS > BCD_MAX_DIGITS || WIDTH < BCD_W) begin : g_param_check
        $error("updown_counter_bcd: need 1 <= DIGITS <= 16 and WIDTH >= 4*DIGITS");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             mode_q;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    action_t          action;
    bcd_vec_t         bcd_cur, bcd_ld_in, bcd_ld;
    bcd_res_t         bcd_up, bcd_dn;
    logic [WIDTH-1:0] load_d;
    logic [WIDTH-1:0] step_val;
    logic             boundary;

    always_comb begin
        bcd_cur                = '0;
        bcd_cur[BCD_W-1:0]     = count_q[BCD_W-1:0];
        bcd_ld_in              = '0;
        bcd_ld_in[BCD_W-1:0]   = load_val[BCD_W-1:0];
    end

    assign bcd_up = bcd_inc(bcd_cur, DIGITS);
    assign bcd_dn = bcd_dec(bcd_cur, DIGITS);
    assign bcd_ld = bcd_clamp(bcd_ld_in, DIGITS);

    // BCD loads drop everything above the live digits
    always_comb begin
        load_d = load_val;
        if (mode == MODE_BCD) begin
            load_d             = '0;
            load_d[BCD_W-1:0]  = bcd_ld[BCD_W-1:0];
        end
    end

    always_comb begin
        if (load)                action = ACT_LOAD;
        else if (mode != mode_q) action = ACT_MODE_CHG;
        else if (hold)           action = ACT_HOLD;
        else if (en)             action = ACT_STEP;
        else                     action = ACT_IDLE;
    end

    // a step only happens with mode == mode_q, so mode_q selects the arithmetic
    always_comb begin
        step_val = count_q;
        boundary = 1'b0;
        if (mode_q == MODE_BCD) begin
            step_val = '0;
            if (up_down) begin
                step_val[BCD_W-1:0] = bcd_up.value[BCD_W-1:0];
                boundary            = bcd_up.carry;
            end else begin
                step_val[BCD_W-1:0] = bcd_dn.value[BCD_W-1:0];
                boundary            = bcd_dn.carry;
            end
        end else begin
            if (up_down) begin
                step_val = count_q + WIDTH'(1);
                boundary = &count_q;
            end else begin
                step_val = count_q - WIDTH'(1);
                boundary = ~|count_q;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = clr_ovf ? 1'b0 : ovf_q;
        case (action)
            ACT_LOAD:     count_d = load_d;
            ACT_MODE_CHG: count_d = '0;
            ACT_STEP: begin
                tc_d = boundary;
                if (boundary) begin
                    ovf_d = 1'b1;
                end
                if (!(boundary && sat)) begin
                    count_d = step_val;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            mode_q  <= MODE_BIN;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            mode_q  <= mode;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

    counter_digit_scan #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .nibbles   (count_q[BCD_W-1:0]),
        .digit_sel (digit_sel),
        .digit_val (digit_val)
    );

endmodule

// File: tb/tb_updown_counter_bcd.sv
// Directed-vector bench for updown_counter_bcd with a queue-based scoreboard;
// expectations are pushed by the stimulus and checked by an independent monitor.
module tb_updown_counter_bcd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, up_down, hold, mode, sat, load, clr_ovf;
    logic [15:0] load_val;
    logic [15:0] count;
    logic        tc, ovf;
    logic [3:0]  digit_sel;
    logic [3:0]  digit_val;

    typedef struct {
        logic [15:0] count;
        logic        tc;
        logic        ovf;
        logic        scan;
        logic [3:0]  sel;
        logic [3:0]  val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    updown_counter_bcd #(
        .WIDTH    (16),
        .DIGITS   (4),
        .SCAN_DIV (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up_down   (up_down),
        .hold      (hold),
        .mode      (mode),
        .sat       (sat),
        .load      (load),
        .load_val  (load_val),
        .clr_ovf   (clr_ovf),
        .count     (count),
        .tc        (tc),
        .ovf       (ovf),
        .digit_sel (digit_sel),
        .digit_val (digit_val)
    );

    // monitor: one expectation per falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (count !== e.count) begin
                    n_err++;
                    $display("FAIL %s count: got %h want %h", e.name, count, e.count);
                end
                if (tc !== e.tc) begin
                    n_err++;
                    $display("FAIL %s tc: got %b want %b", e.name, tc, e.tc);
                end
                if (ovf !== e.ovf) begin
                    n_err++;
                    $display("FAIL %s ovf: got %b want %b", e.name, ovf, e.ovf);
                end
                if (e.scan) begin
                    if (digit_sel !== e.sel) begin
                        n_err++;
                        $display("FAIL %s digit_sel: got %b want %b", e.name, digit_sel, e.sel);
                    end
                    if (digit_val !== e.val) begin
                        n_err++;
                        $display("FAIL %s digit_val: got %h want %h", e.name, digit_val, e.val);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    task automatic push(input logic [15:0] c, input logic t, input logic o,
                        input logic s, input logic [3:0] sl, input logic [3:0] v,
                        input string name);
        exp_t e;
        e.count = c; e.tc = t; e.ovf = o; e.scan = s; e.sel = sl; e.val = v; e.name = name;
        q.push_back(e);
    endtask

    task automatic expect_edge(input logic [15:0] c, input logic t, input logic o,
                               input string name);
        push(c, t, o, 1'b0, 4'h0, 4'h0, name);
        @(negedge clk);
        #1;
    endtask

    task automatic expect_scan(input logic [15:0] c, input logic t, input logic o,
                               input logic [3:0] sl, input logic [3:0] v, input string name);
        push(c, t, o, 1'b1, sl, v, name);
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] nib_tab [4];
        int         idx;
        nib_tab = '{4'h4, 4'h3, 4'h2, 4'h1};

        rst_n = 1'b0; en = 1'b0; up_down = 1'b1; hold = 1'b0; mode = 1'b0;
        sat = 1'b0; load = 1'b0; clr_ovf = 1'b0; load_val = '0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // reset with ovf set and count mid-value
        load = 1; load_val = 16'hFFFF;               expect_edge(16'hFFFF, 0, 0, "bin_load_ffff");
        load = 0; en = 1; up_down = 1;               expect_edge(16'h0000, 1, 1, "bin_wrap_up");
        en = 0; load = 1; load_val = 16'h1234;       expect_edge(16'h1234, 0, 1, "load_1234");
        load = 0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        push(16'h0000, 0, 0, 1'b1, 4'b0001, 4'h0, "async_reset");
        @(negedge clk);
        #1 rst_n = 1'b1;

        // scanner from a fresh prescaler; first edge loads, then hold
        for (int k = 1; k <= 17; k++) begin
            load = (k == 1); hold = (k != 1); load_val = 16'h1234;
            idx = (k / 4) % 4;
            expect_scan(16'h1234, 0, 0, 4'(1 << idx), nib_tab[idx], $sformatf("scan_%0d", k));
        end

        // BCD up through MAX, then down through 0
        hold = 0; mode = 1; load = 1; load_val = 16'h9998;
                                                     expect_edge(16'h9998, 0, 0, "bcd_load_9998");
        load = 0; en = 1; up_down = 1;               expect_edge(16'h9999, 0, 0, "bcd_up_9999");
                                                     expect_edge(16'h0000, 1, 1, "bcd_up_wrap");
                                                     expect_edge(16'h0001, 0, 1, "bcd_up_0001");
        up_down = 0;                                 expect_edge(16'h0000, 0, 1, "bcd_dn_0000");
                                                     expect_edge(16'h9999, 1, 1, "bcd_dn_wrap");
                                                     expect_edge(16'h9998, 0, 1, "bcd_dn_9998");
        en = 0; load = 1; load_val = 16'h0109;       expect_edge(16'h0109, 0, 1, "bcd_load_0109");
        load = 0; en = 1; up_down = 1;               expect_edge(16'h0110, 0, 1, "bcd_carry");

        // binary saturate at 0, then binary wrap both ways
        en = 0; mode = 0; load = 1; load_val = 16'h0001; sat = 1; clr_ovf = 1;
                                                     expect_edge(16'h0001, 0, 0, "sat_load_clr");
        clr_ovf = 0; load = 0; en = 1; up_down = 0;  expect_edge(16'h0000, 0, 0, "sat_dn_1");
                                                     expect_edge(16'h0000, 1, 1, "sat_dn_2");
                                                     expect_edge(16'h0000, 1, 1, "sat_dn_3");
        sat = 0; en = 0; load = 1; load_val = 16'hFFFF;
                                                     expect_edge(16'hFFFF, 0, 1, "bin_load_max");
        load = 0; en = 1; up_down = 1;               expect_edge(16'h0000, 1, 1, "bin_up_wrap");
        up_down = 0;                                 expect_edge(16'hFFFF, 1, 1, "bin_dn_wrap");

        // priority: hold over en; load over hold and mode change
        en = 0; load = 1; load_val = 16'h0500;       expect_edge(16'h0500, 0, 1, "prio_load");
        load = 0; hold = 1; en = 1; up_down = 1;     expect_edge(16'h0500, 0, 1, "hold_1");
                                                     expect_edge(16'h0500, 0, 1, "hold_2");
        load = 1; mode = 1; load_val = 16'h00AB;     expect_edge(16'h0099, 0, 1, "load_clamp_ab");
        load_val = 16'hA5F3;                         expect_edge(16'h9593, 0, 1, "load_clamp_a5f3");
        load = 0; mode = 0;                          expect_edge(16'h0000, 0, 1, "mode_over_hold");
        hold = 0; en = 0;

        // mode change keeps ovf; clr_ovf loses to a boundary step
        load = 1; load_val = 16'h00FF;               expect_edge(16'h00FF, 0, 1, "bin_load_00ff");
        load = 0; mode = 1;                          expect_edge(16'h0000, 0, 1, "mode_chg_clear");
                                                     expect_edge(16'h0000, 0, 1, "idle_no_en");
        clr_ovf = 1;                                 expect_edge(16'h0000, 0, 0, "clr_ovf");
        en = 1; up_down = 0; sat = 0;                expect_edge(16'h9999, 1, 1, "clr_vs_boundary");
        clr_ovf = 0; en = 0;                         expect_edge(16'h9999, 0, 1, "tc_drops");

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
